alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parameterised multi-cycle ALU for the MIPS datapath.
- Replaces the purely combinational ALU wherever multiply/divide or handshake-based stalling is needed.
- Single-cycle ops complete one cycle after acceptance. MUL/DIVU run an iterative shift-add / restoring-division engine and take WIDTH+1 cycles.
- Uses a valid/ready handshake on input and output, so the control unit can stall.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept (high only in IDLE)
op  input  4  operation code (see Behaviour)
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  primary result (low product / quotient / logic/arith result)
result_hi  output  WIDTH  high product / remainder; 0 for single-cycle ops
zero_flag  output  1  result == 0
ovf_flag  output  1  signed overflow on ADD/SUB; 0 otherwise
dz_flag  output  1  DIVU with src_b == 0
illegal_op  output  1  op code not in table

Behaviour:
- Reset: clk and rst only; rst asynchronous, active-high.
  - On reset: state=IDLE, in_ready=1, out_valid=0, and result, result_hi and all flags =0.
  - Reset mid-operation aborts the operation; no result is produced.
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 3 NOP (result 0).
  - 4 SUB, 5 MUL (unsigned), 6 SLTU (A<B unsigned ->1), 7 SLT (signed compare).
  - 8 DIVU (unsigned). 9-15 illegal.
- Accept: an operation is captured on the rising edge where in_valid & in_ready. Operands and op are registered, so inputs may change afterwards.
- States:
  - IDLE: in_ready=1.
    - On accept of a single-cycle or illegal op: compute, register outputs, go to DONE.
    - On accept of MUL/DIVU: load the engine, counter=WIDTH, go to BUSY.
  - BUSY: in_ready=0; one iteration per cycle; counter decrements.
    - When the counter reaches 0 after the final iteration: register results, go to DONE.
  - DONE: out_valid=1; outputs stable until out_valid & out_ready.
    - On handshake: go to IDLE, out_valid=0 next cycle.
    - There is no same-cycle re-accept; the minimum issue interval is 2 cycles.
- Latency, accept edge to out_valid high:
  - Single-cycle/illegal ops: 1 cycle.
  - MUL/DIVU: WIDTH+1 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf_flag = sign(A)==sign(B') && sign(R)!=sign(A), where B'=B for ADD and ~B+1 for SUB.
  - MUL: full 2*WIDTH product; {result_hi,result}=A*B.
  - DIVU: restoring algorithm; result=quotient, result_hi=remainder.
  - DIVU with B==0: run the full WIDTH iterations. The natural outcome is required: quotient all ones, remainder=A, dz_flag=1.
- zero_flag is evaluated on result only; it is valid whenever out_valid=1.
- Illegal op: result=0, result_hi=0, zero_flag=1, illegal_op=1, 1-cycle latency.
- Flags that do not apply to an op are 0.
- in_valid asserted while in_ready=0 is ignored; it is not queued.
- Back-pressure: out_ready low for any number of cycles holds all outputs unchanged.

Decomposition:
- Shared package alu_pkg:
  - op-code localparams (OP_AND..OP_DIVU).
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE).
  - Helper function is_multicycle(op).
- One sub-module, alu_iter_engine (WIDTH parameter), holds the shift-add multiply and restoring-divide datapath:
  - Inputs: load, step, mode.
  - Outputs: lo/hi accumulators.
  - The top level owns the FSM, counter, handshake and single-cycle datapath.

Test Plan:
- Reset during BUSY of MUL (cycle 5), WIDTH=32 -> out_valid=0, in_ready=1 immediately. Next ADD 2+3 -> result=5, latency 1, zero=0.
- SUB 0x80000000-1, then ADD 0x7FFFFFFF+1 -> results 0x7FFFFFFF and 0x80000000, ovf_flag=1 both. SUB 5-5 -> result=0, zero_flag=1, ovf=0.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles result=0x00000001, result_hi=0xFFFFFFFE. Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
- DIVU 100/7 -> result=14, result_hi=2. DIVU 0x1234/0 -> result=0xFFFFFFFF, result_hi=0x1234, dz_flag=1.
- SLT 0xFFFFFFFF vs 1 -> result=1. SLTU same operands -> result=0. op=12 -> illegal_op=1, result=0, zero_flag=1.
- WIDTH=8 instance: MUL 0xFF*0x02 -> result=0xFE, result_hi=0x01, latency 9 cycles. in_valid during BUSY ignored: exactly one out_valid pulse per accepted op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and engine modes.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOP  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } eng_mode_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath: shift-add unsigned multiply and restoring unsigned divide,
// one iteration per step; {hi,lo} holds product or {remainder,quotient}.
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  eng_mode_t        mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  eng_mode_t        mode_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_take;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_take  = (div_shift >= {1'b0, b_q});
    // A successful subtract always leaves a value below b, so the low bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - b_q;
  end

  // NOTE: datapath registers carry no reset; the top only exposes them after a
  // full load+iterate sequence, so their power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (load) begin
      mode_q <= mode;
      b_q    <= b;
      lo_q   <= a;
      hi_q   <= '0;
    end else if (step) begin
      if (mode_q == MODE_MUL) begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_q <= div_take ? div_diff : div_shift[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], div_take};
      end
    end
  end

  assign lo = lo_q;
  assign hi = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: valid/ready handshake FSM, iteration counter, single-cycle
// datapath and result/flag registers around the iterative mul/div engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             dz_flag,
  output logic             illegal_op
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             use_eng_q, ovf_q, dz_q, ill_q;

  logic             accept, eng_load, eng_step;
  eng_mode_t        eng_mode;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  logic [WIDTH-1:0] add_res, sub_res, b_neg;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf, sc_ill;

  assign in_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept   = in_valid && in_ready;
  assign eng_load = accept && is_multicycle(op);
  assign eng_step = (state == ST_BUSY);
  assign eng_mode = (op == OP_DIVU) ? MODE_DIV : MODE_MUL;

  alu_iter_engine #(.WIDTH(WIDTH)) u_engine (
    .clk  (clk),
    .load (eng_load),
    .step (eng_step),
    .mode (eng_mode),
    .a    (src_a),
    .b    (src_b),
    .lo   (eng_lo),
    .hi   (eng_hi)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    add_res = src_a + src_b;
    sub_res = src_a - src_b;
    b_neg   = ~src_b + WIDTH'(1);
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_ill  = 1'b0;
    case (op)
      OP_AND:  sc_res = src_a & src_b;
      OP_OR:   sc_res = src_a | src_b;
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (src_a[MSB] == src_b[MSB]) && (add_res[MSB] != src_a[MSB]);
      end
      OP_NOP:  sc_res = '0;
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (src_a[MSB] == b_neg[MSB]) && (sub_res[MSB] != src_a[MSB]);
      end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_MUL, OP_DIVU: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_multicycle(op) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      use_eng_q   <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (is_multicycle(op)) begin
          cnt       <= CNT_W'(WIDTH);
          use_eng_q <= 1'b1;
          ovf_q     <= 1'b0;
          ill_q     <= 1'b0;
          dz_q      <= (op == OP_DIVU) && (src_b == '0);
        end else begin
          result_q    <= sc_res;
          result_hi_q <= '0;
          use_eng_q   <= 1'b0;
          ovf_q       <= sc_ovf;
          ill_q       <= sc_ill;
          dz_q        <= 1'b0;
        end
      end else if (state == ST_BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Engine results are read straight from its registers once the last step lands.
  assign result     = use_eng_q ? eng_lo : result_q;
  assign result_hi  = use_eng_q ? eng_hi : result_hi_q;
  assign zero_flag  = out_valid && (result == '0);
  assign ovf_flag   = ovf_q;
  assign dz_flag    = dz_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, reset abort, back-pressure,
// randomized ops against an arithmetic reference model, and a WIDTH=8 instance.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, result, result_hi;
  logic        zero_flag, ovf_flag, dz_flag, illegal_op;

  logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8;
  logic [3:0]  op_8;
  logic [7:0]  src_a_8, src_b_8, result_8, result_hi_8;
  logic        zero_flag_8, ovf_flag_8, dz_flag_8, illegal_op_8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero_flag(zero_flag),
    .ovf_flag(ovf_flag), .dz_flag(dz_flag), .illegal_op(illegal_op)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
    .src_a(src_a_8), .src_b(src_b_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .result_hi(result_hi_8), .zero_flag(zero_flag_8),
    .ovf_flag(ovf_flag_8), .dz_flag(dz_flag_8), .illegal_op(illegal_op_8)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dz;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    int          lat;
    int          hold;
    bit          junk;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the op-code table.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      s_sum;
    logic [63:0] prod;
    logic [31:0] bp;
    e = '{res: 32'd0, hi: 32'd0, zero: 1'b0, ovf: 1'b0, dz: 1'b0, ill: 1'b0};
    case (o)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2, 4'd4: begin
        bp    = (o == 4'd2) ? b : (32'd0 - b);
        s_sum = longint'($signed(a)) + longint'($signed(bp));
        e.res = a + bp;
        e.ovf = (s_sum > 64'sd2147483647) || (s_sum < -64'sd2147483648);
      end
      4'd3: e.res = 32'd0;
      4'd5: begin
        prod = {32'd0, a} * {32'd0, b};
        e.res = prod[31:0];
        e.hi  = prod[63:32];
      end
      4'd6: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin
        if (b == 32'd0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi  = a;
          e.dz  = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Caller is positioned #1 after a rising edge.
  task automatic run32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input int lat_exp, input int hold, input bit junk,
                       input string tag);
    int lat;
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = junk; op = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_result"}, result, e.res);
    check({tag, "_result_hi"}, result_hi, e.hi);
    check({tag, "_zero"}, zero_flag, e.zero);
    check({tag, "_ovf"}, ovf_flag, e.ovf);
    check({tag, "_dz"}, dz_flag, e.dz);
    check({tag, "_illegal"}, illegal_op, e.ill);
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_result"}, result, e.res);
      check({tag, "_hold_result_hi"}, result_hi, e.hi);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
    if (junk) begin
      @(posedge clk); #1;
      check({tag, "_no_queued"}, out_valid, 0);
    end
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [7:0] eh, input logic eo,
                      input logic ed, input int lat_exp, input bit junk, input string tag);
    int lat;
    op_8 = o; src_a_8 = a; src_b_8 = b; in_valid_8 = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = junk; op_8 = 4'($urandom_range(0, 8)); src_a_8 = 8'($urandom);
    lat = 1;
    while (!out_valid_8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_result"}, result_8, er);
    check({tag, "_result_hi"}, result_hi_8, eh);
    check({tag, "_ovf"}, ovf_flag_8, eo);
    check({tag, "_dz"}, dz_flag_8, ed);
    in_valid_8 = 1'b0; out_ready_8 = 1'b1;
    @(posedge clk); #1;
    out_ready_8 = 1'b0;
    check({tag, "_post_valid"}, out_valid_8, 0);
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_no_queued"}, out_valid_8, 0);
  endtask

  vec_t vecs[14];

  initial begin
    exp_t e;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{4'd2,  32'd2,          32'd3,          '{32'd5,          32'd0,          1'b0, 1'b0, 1'b0, 1'b0},  1,  0, 1'b0, "add_2_3"};
    vecs[1]  = '{4'd4,  32'h8000_0000,  32'd1,          '{32'h7FFF_FFFF,  32'd0,          1'b0, 1'b1, 1'b0, 1'b0},  1,  0, 1'b0, "sub_ovf"};
    vecs[2]  = '{4'd2,  32'h7FFF_FFFF,  32'd1,          '{32'h8000_0000,  32'd0,          1'b0, 1'b1, 1'b0, 1'b0},  1,  0, 1'b0, "add_ovf"};
    vecs[3]  = '{4'd4,  32'd5,          32'd5,          '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0},  1,  0, 1'b0, "sub_zero"};
    vecs[4]  = '{4'd5,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  '{32'd1,          32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 1'b0},  33, 10, 1'b0, "mul_max"};
    vecs[5]  = '{4'd8,  32'd100,        32'd7,          '{32'd14,         32'd2,          1'b0, 1'b0, 1'b0, 1'b0},  33, 0, 1'b0, "divu_100_7"};
    vecs[6]  = '{4'd8,  32'h1234,       32'd0,          '{32'hFFFF_FFFF,  32'h1234,       1'b0, 1'b0, 1'b1, 1'b0},  33, 0, 1'b0, "divu_by_0"};
    vecs[7]  = '{4'd7,  32'hFFFF_FFFF,  32'd1,          '{32'd1,          32'd0,          1'b0, 1'b0, 1'b0, 1'b0},  1,  0, 1'b0, "slt"};
    vecs[8]  = '{4'd6,  32'hFFFF_FFFF,  32'd1,          '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0},  1,  0, 1'b0, "sltu"};
    vecs[9]  = '{4'd12, 32'h55,         32'hAA,         '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1'b1},  1,  0, 1'b0, "illegal_12"};
    vecs[10] = '{4'd0,  32'hF0F0_F0F0,  32'hFF00_FF00,  '{32'hF000_F000,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0},  1,  0, 1'b1, "and"};
    vecs[11] = '{4'd1,  32'h0F0F_0000,  32'h0000_00F0,  '{32'h0F0F_00F0,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0},  1,  2, 1'b0, "or"};
    vecs[12] = '{4'd3,  32'h1234,       32'h5678,       '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0},  1,  0, 1'b0, "nop"};
    vecs[13] = '{4'd5,  32'h0001_0000,  32'h0001_0000,  '{32'd0,          32'd1,          1'b1, 1'b0, 1'b0, 1'b0},  33, 0, 1'b1, "mul_lo_zero"};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; src_a = '0; src_b = '0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0; op_8 = '0; src_a_8 = '0; src_b_8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {result_hi, result}, 64'd0);
    check("rst_flags", {zero_flag, ovf_flag, dz_flag, illegal_op}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Abort a MUL five cycles into its run with an asynchronous reset.
    op = 4'd5; src_a = 32'hFFFF_FFFF; src_b = 32'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", {result_hi, result}, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat,
            vecs[i].hold, vecs[i].junk, vecs[i].name);

    for (int n = 0; n < 40; n++) begin
      ro = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      if (n % 5 == 0) ra = 32'($urandom_range(0, 1000));
      e = model(ro, ra, rb);
      run32(ro, ra, rb, e, ((ro == 4'd5) || (ro == 4'd8)) ? 33 : 1,
            $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", n, ro));
    end

    run8(4'd5, 8'hFF, 8'h02, 8'hFE, 8'h01, 1'b0, 1'b0, 9, 1'b1, "w8_mul");
    run8(4'd8, 8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b0, 1'b1, 9, 1'b0, "w8_divu_0");
    run8(4'd8, 8'hC8, 8'h0D, 8'h0F, 8'h05, 1'b0, 1'b0, 9, 1'b1, "w8_divu");
    run8(4'd2, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1, 1'b0, "w8_add_ovf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
